// File: rtl/mem_stall_arbiter_pkg.sv
// Shared types and constants for the memory stall arbiter.
package mem_arb_pkg;

  // Width of the read-latency counter (LAT up to 15).
  localparam int LAT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_ISSUE = 3'd1,
    D_WAIT  = 3'd2,
    F_ISSUE = 3'd3,
    F_WAIT  = 3'd4,
    DONE    = 3'd5
  } arb_state_t;

  typedef enum logic {
    ACC_WORD  = 1'b0,
    ACC_DWORD = 1'b1
  } acc_size_t;

endpackage

// File: rtl/mem_stall_arbiter_if.sv
// Core-side and memory-side bus of the stall arbiter.
// Handshake: the core raises i_req / d_read / d_write and holds every request
// input stable while stall is high; results on i_rdata / d_rdata are valid in
// the first cycle stall is low. On the memory side m_req is a one-cycle strobe
// qualified by m_we, and m_rdata is valid exactly LAT cycles after a read strobe.
interface mem_stall_arbiter_if #(
  parameter int N  = 64,
  parameter int AW = 32
);
  logic          i_req;
  logic [AW-1:0] i_adr;
  logic [31:0]   i_rdata;
  logic          d_read;
  logic          d_write;
  logic          d_dword;
  logic [AW-1:0] d_adr;
  logic [N-1:0]  d_wdata;
  logic [N-1:0]  d_rdata;
  logic          stall;
  logic          m_req;
  logic          m_we;
  logic [N/8-1:0] m_be;
  logic [AW-1:0] m_adr;
  logic [N-1:0]  m_wdata;
  logic [N-1:0]  m_rdata;

  // Arbiter side.
  modport slave (
    input  i_req, i_adr, d_read, d_write, d_dword, d_adr, d_wdata, m_rdata,
    output i_rdata, d_rdata, stall, m_req, m_we, m_be, m_adr, m_wdata
  );

  // Core + memory side.
  modport master (
    output i_req, i_adr, d_read, d_write, d_dword, d_adr, d_wdata, m_rdata,
    input  i_rdata, d_rdata, stall, m_req, m_we, m_be, m_adr, m_wdata
  );
endinterface

// File: rtl/mem_stall_arbiter_lane_sel.sv
// Lane extract, write replication and byte-enable generation for an N-bit bus.
module mem_lane_sel
  import mem_arb_pkg::*;
#(
  parameter int N = 64
) (
  input  logic           lane,
  input  acc_size_t      size,
  input  logic [N-1:0]   rword,
  input  logic [31:0]    wdata32,
  output logic [31:0]    rdata32,
  output logic [N-1:0]   wdata_rep,
  output logic [N/8-1:0] be
);

  generate
    if (N == 64) begin : g_n64
      // Two 32-bit lanes; lane 0 is the low half.
      always_comb begin
        rdata32   = lane ? rword[63:32] : rword[31:0];
        wdata_rep = {wdata32, wdata32};
        if (size == ACC_DWORD) be = 8'hFF;
        else                   be = lane ? 8'hF0 : 8'h0F;
      end
    end else begin : g_n32
      // Single lane: everything passes straight through.
      always_comb begin
        rdata32   = rword[31:0];
        wdata_rep = wdata32;
        be        = 4'hF;
      end
    end
  endgenerate

endmodule

// File: rtl/mem_stall_arbiter.sv
// Serialises the core's data and fetch accesses onto one fixed-latency memory
// port and holds the core with a combinational stall.
module mem_stall_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N   = 64,
  parameter int AW  = 32,
  parameter int LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  mem_stall_arbiter_if.slave  bus,
  output logic                err,
  output logic [31:0]         stall_cnt,
  output arb_state_t          dbg_state
);

  localparam int                   OFF_W    = (N == 64) ? 3 : 2;
  localparam logic [AW-1:0]        ADR_MASK = ~AW'(N / 8 - 1);
  localparam logic [LAT_CNT_W-1:0] LAT_C    = LAT_CNT_W'(LAT);

  arb_state_t           state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          i_hold_q, i_hold_d;
  logic [N-1:0]         d_hold_q, d_hold_d;
  logic                 err_q, err_d;
  logic [31:0]          stall_cnt_q, stall_cnt_d;

  logic           d_req, any_req, fetch_phase, lane, bad_d, bad_i;
  acc_size_t      size;
  logic [31:0]    lane_rd;
  logic [N-1:0]   lane_wr, rd32_ext;
  logic [N/8-1:0] lane_be;

  // Request decode, lane choice (fetch lane while fetching) and misalignment checks.
  always_comb begin
    d_req       = bus.d_read | bus.d_write;
    any_req     = d_req | bus.i_req;
    size        = (bus.d_dword && (N == 64)) ? ACC_DWORD : ACC_WORD;
    fetch_phase = (state_q == F_ISSUE) || (state_q == F_WAIT);
    lane        = (N == 64) ? (fetch_phase ? bus.i_adr[2] : bus.d_adr[2]) : 1'b0;
    bad_d       = d_req & ((bus.d_dword & (bus.d_adr[OFF_W-1:0] != '0)) |
                           (!bus.d_dword & (bus.d_adr[1:0] != 2'b00)) |
                           (bus.d_dword & (N == 32)));
    bad_i       = bus.i_req & (bus.i_adr[1:0] != 2'b00);
    rd32_ext        = '0;
    rd32_ext[31:0]  = lane_rd;
  end

  mem_lane_sel #(.N(N)) u_lane_sel (
    .lane      (lane),
    .size      (size),
    .rword     (bus.m_rdata),
    .wdata32   (bus.d_wdata[31:0]),
    .rdata32   (lane_rd),
    .wdata_rep (lane_wr),
    .be        (lane_be)
  );

  // Sequencing: data access first, then fetch, then one DONE cycle releasing the core.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_hold_d    = i_hold_q;
    d_hold_d    = d_hold_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      IDLE: begin
        if (d_req)           state_d = D_ISSUE;
        else if (bus.i_req)  state_d = F_ISSUE;
        if (any_req && (bad_d || bad_i)) err_d = 1'b1;
      end
      D_ISSUE: begin
        if (bus.d_write) begin
          state_d = bus.i_req ? F_ISSUE : DONE;
        end else begin
          state_d = D_WAIT;
          cnt_d   = LAT_CNT_W'(1);
        end
      end
      D_WAIT: begin
        if (cnt_q == LAT_C) begin
          d_hold_d = (size == ACC_DWORD) ? bus.m_rdata : rd32_ext;
          state_d  = bus.i_req ? F_ISSUE : DONE;
        end else begin
          cnt_d = cnt_q + LAT_CNT_W'(1);
        end
      end
      F_ISSUE: begin
        state_d = F_WAIT;
        cnt_d   = LAT_CNT_W'(1);
      end
      F_WAIT: begin
        if (cnt_q == LAT_C) begin
          i_hold_d = lane_rd;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + LAT_CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // State, latency counter, result holding registers, sticky error and stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      i_hold_q    <= '0;
      d_hold_q    <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      i_hold_q    <= i_hold_d;
      d_hold_q    <= d_hold_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Memory strobes are decoded from the issue states so they are zero outside them.
  assign bus.m_req   = (state_q == D_ISSUE) || (state_q == F_ISSUE);
  assign bus.m_we    = (state_q == D_ISSUE) && bus.d_write;
  assign bus.m_adr   = (state_q == D_ISSUE) ? (bus.d_adr & ADR_MASK) :
                       (state_q == F_ISSUE) ? (bus.i_adr & ADR_MASK) : '0;
  assign bus.m_be    = bus.m_we ? lane_be : '0;
  assign bus.m_wdata = bus.m_we ? ((size == ACC_DWORD) ? bus.d_wdata : lane_wr) : '0;
  assign bus.stall   = any_req && (state_q != DONE);
  assign bus.i_rdata = i_hold_q;
  assign bus.d_rdata = d_hold_q;
  assign err         = err_q;
  assign stall_cnt   = stall_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_stall_arbiter.sv
// Bench for mem_stall_arbiter (N=64, LAT=2): directed scenarios plus random
// transactions compared against a transaction-level model.
module tb_mem_stall_arbiter;
  import mem_arb_pkg::*;

  localparam int N   = 64;
  localparam int AW  = 32;
  localparam int LAT = 2;

  typedef struct packed {
    logic [7:0]  cyc;
    logic        we;
    logic [31:0] adr;
    logic [7:0]  be;
    logic [63:0] wdata;
  } acc_t;

  logic       clk;
  logic       reset;
  logic       err;
  logic [31:0] stall_cnt;
  arb_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  // Memory as seen by the DUT, and the model's own copy.
  logic [63:0] env_mem [32];
  logic [63:0] ref_mem [32];
  logic [63:0] rd_pipe [LAT];

  // Model state.
  logic [31:0] i_exp;
  logic [63:0] d_exp;
  logic        err_exp;
  logic [31:0] cnt_exp;

  mem_stall_arbiter_if #(.N(N), .AW(AW)) bus ();

  mem_stall_arbiter #(.N(N), .AW(AW), .LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err       (err),
    .stall_cnt (stall_cnt),
    .dbg_state (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: byte-enabled writes, reads returned LAT cycles after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (bus.m_req && bus.m_we)
      for (int b = 0; b < 8; b++)
        if (bus.m_be[b]) env_mem[bus.m_adr[7:3]][8*b +: 8] = bus.m_wdata[8*b +: 8];
    for (int s = LAT - 1; s > 0; s--) rd_pipe[s] <= rd_pipe[s-1];
    rd_pipe[0] <= (bus.m_req && !bus.m_we) ? env_mem[bus.m_adr[7:3]] : {$urandom, $urandom};
  end
  assign bus.m_rdata = rd_pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drop_reqs();
    bus.i_req = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_dword = 1'b0;
  endtask

  task automatic model_reset();
    i_exp = '0; d_exp = '0; err_exp = 1'b0; cnt_exp = '0;
  endtask

  // One core request, from IDLE to the release cycle, checked end to end.
  task automatic run_txn(input logic ireq, input logic [31:0] iadr, input logic dread,
                         input logic dwrite, input logic ddword, input logic [31:0] dadr,
                         input logic [63:0] dwdata);
    acc_t exp_q[$];
    acc_t obs_q[$];
    acc_t a;
    logic data;
    logic done;
    int   exp_stall, n_stall;
    logic [63:0] w;

    data = dread | dwrite;
    if (data) begin
      a = '0;
      a.cyc = 8'd1;
      a.we  = dwrite;
      a.adr = dadr & ~32'h7;
      if (dwrite) begin
        a.be    = ddword ? 8'hFF : (dadr[2] ? 8'hF0 : 8'h0F);
        a.wdata = ddword ? dwdata : {dwdata[31:0], dwdata[31:0]};
        for (int b = 0; b < 8; b++)
          if (a.be[b]) ref_mem[dadr[7:3]][8*b +: 8] = a.wdata[8*b +: 8];
      end else begin
        w = ref_mem[dadr[7:3]];
        d_exp = ddword ? w : (dadr[2] ? {32'h0, w[63:32]} : {32'h0, w[31:0]});
      end
      exp_q.push_back(a);
    end
    if (ireq) begin
      a = '0;
      a.cyc = data ? (dwrite ? 8'd2 : 8'(2 + LAT)) : 8'd1;
      a.adr = iadr & ~32'h7;
      w = ref_mem[iadr[7:3]];
      i_exp = iadr[2] ? w[63:32] : w[31:0];
      exp_q.push_back(a);
    end
    exp_stall = 1 + (data ? (dwrite ? 1 : 1 + LAT) : 0) + (ireq ? 1 + LAT : 0);
    cnt_exp += 32'(exp_stall);
    if (data && ((ddword && dadr[2:0] != 3'b0) || (!ddword && dadr[1:0] != 2'b0))) err_exp = 1'b1;
    if (ireq && iadr[1:0] != 2'b0) err_exp = 1'b1;

    @(negedge clk);
    bus.i_req = ireq; bus.i_adr = iadr; bus.d_read = dread; bus.d_write = dwrite;
    bus.d_dword = ddword; bus.d_adr = dadr; bus.d_wdata = dwdata;
    n_stall = 0;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (bus.m_req) begin
        a.cyc = 8'(c); a.we = bus.m_we; a.adr = bus.m_adr; a.be = bus.m_be; a.wdata = bus.m_wdata;
        obs_q.push_back(a);
      end
      if (bus.stall) n_stall++;
      else done = 1'b1;
      if (!done) @(negedge clk);
    end
    chk("release_seen", 64'(done), 64'd1);
    chk("stall_cycles", 64'(n_stall), 64'(exp_stall));
    chk("i_rdata", 64'(bus.i_rdata), 64'(i_exp));
    chk("d_rdata", bus.d_rdata, d_exp);
    chk("err", 64'(err), 64'(err_exp));
    chk("stall_cnt", 64'(stall_cnt), 64'(cnt_exp));
    drop_reqs();
    chk("access_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      chk("m_req_cycle", 64'(obs_q[k].cyc), 64'(exp_q[k].cyc));
      chk("m_we", 64'(obs_q[k].we), 64'(exp_q[k].we));
      chk("m_adr", 64'(obs_q[k].adr), 64'(exp_q[k].adr));
      if (exp_q[k].we) begin
        chk("m_be", 64'(obs_q[k].be), 64'(exp_q[k].be));
        chk("m_wdata", obs_q[k].wdata, exp_q[k].wdata);
      end
    end
    @(negedge clk);
    #1;
    chk("idle_stall", 64'(bus.stall), 64'd0);
    chk("idle_m_req", 64'(bus.m_req), 64'd0);
  endtask

  initial begin
    int          kind;
    logic        dw, both, rd, wr, fi;
    logic [31:0] da, ia;
    logic [63:0] wd;

    for (int i = 0; i < 32; i++) begin
      env_mem[i] = {$urandom, $urandom};
      ref_mem[i] = env_mem[i];
    end
    for (int s = 0; s < LAT; s++) rd_pipe[s] = '0;
    env_mem[8] = 64'h11112222_33334444;
    ref_mem[8] = 64'h11112222_33334444;
    bus.i_adr = '0; bus.d_adr = '0; bus.d_wdata = '0;
    drop_reqs();
    model_reset();

    // Reset held low for three cycles.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_m_req", 64'(bus.m_req), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_i_rdata", 64'(bus.i_rdata), 64'd0);
    chk("rst_d_rdata", bus.d_rdata, 64'd0);

    // Fetch only from 0x44: upper lane of the word at 0x40.
    run_txn(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("fetch_44_i_rdata", 64'(bus.i_rdata), 64'h11112222);

    // Word read 0x10 then fetch 0x20.
    run_txn(1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 32'h10, 64'h0);

    // Word write 0x0C (upper lane) then fetch.
    run_txn(1'b1, 32'h30, 1'b0, 1'b1, 1'b0, 32'h0C, 64'h12345678_DEADBEEF);

    // Read back the written upper lane.
    run_txn(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0C, 64'h0);
    chk("readback_0c", bus.d_rdata, 64'h00000000_DEADBEEF);

    // Random aligned traffic.
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 4));
      dw   = 1'($urandom_range(0, 1));
      both = ($urandom_range(0, 7) == 0);
      da   = dw ? ($urandom_range(0, 31) << 3) : ($urandom_range(0, 63) << 2);
      ia   = $urandom_range(0, 63) << 2;
      wd   = {$urandom, $urandom};
      fi   = (kind == 0) || (kind == 2) || (kind == 4);
      wr   = (kind >= 3);
      rd   = (kind == 1) || (kind == 2) || (wr && both);
      run_txn(fi, ia, rd, wr, dw, da, wd);
    end

    // Misaligned dword read: flagged, but completes on the masked address.
    run_txn(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h44, 64'h0);
    chk("dword_44_d_rdata", bus.d_rdata, 64'h11112222_33334444);
    chk("err_sticky", 64'(err), 64'd1);

    // Random traffic with occasional misalignment while err is already set.
    for (int t = 0; t < 10; t++) begin
      da = $urandom_range(0, 255);
      ia = $urandom_range(0, 255);
      run_txn(1'($urandom_range(0, 1)), ia, 1'b1, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), da, {$urandom, $urandom});
    end

    // Reset in the middle of a read's wait phase.
    @(negedge clk);
    bus.d_read = 1'b1; bus.d_dword = 1'b1; bus.d_adr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_state", 64'(dbg_state), 64'(D_WAIT));
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_m_req", 64'(bus.m_req), 64'd0);
    chk("mid_rst_m_adr", 64'(bus.m_adr), 64'd0);
    chk("mid_rst_i_rdata", 64'(bus.i_rdata), 64'd0);
    chk("mid_rst_d_rdata", bus.d_rdata, 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("mid_rst_stall_follows_req", 64'(bus.stall), 64'd1);
    drop_reqs();
    #1;
    chk("mid_rst_stall_low", 64'(bus.stall), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_d_rdata", bus.d_rdata, 64'd0);
    chk("post_rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("post_rst_state", 64'(dbg_state), 64'(IDLE));

    // Normal operation after the aborted read.
    run_txn(1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 32'h40, 64'h0);
    run_txn(1'b1, 32'h8, 1'b0, 1'b1, 1'b1, 32'h18, {$urandom, $urandom});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
